// File: rtl/hdmi_cfg_pkg.sv
// Shared types and the default register table for the HDMI configuration sequencer.
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBresp   = 2'b01;
  localparam logic [1:0] ErrRead    = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cfg_entry_t;

  localparam int unsigned DefaultEntries = 4;

  localparam cfg_entry_t DefaultTable [DefaultEntries] = '{
    '{addr: 32'h0000_0000, data: 32'h0000_0001},
    '{addr: 32'h0000_0004, data: 32'h0000_0002},
    '{addr: 32'h0000_0008, data: 32'h0000_0003},
    '{addr: 32'h0000_000C, data: 32'h0000_0004}
  };

  // Entries beyond the default table continue the same word-stride pattern.
  function automatic cfg_entry_t default_entry(logic [3:0] idx);
    cfg_entry_t e;
    if (idx < 4'(DefaultEntries)) begin
      e = DefaultTable[idx[1:0]];
    end else begin
      e.addr = {26'b0, idx, 2'b00};
      e.data = {28'b0, idx} + 32'd1;
    end
    return e;
  endfunction

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational lookup of one configuration table entry by index.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [31:0] addr,
  output logic [31:0] data
);

  cfg_entry_t entry;

  assign entry = default_entry(index);
  assign addr  = entry.addr;
  assign data  = entry.data;

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// AXI4-Lite master that writes a register table and optionally reads it back to verify.
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned VERIFY      = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  err_index,
  output logic [1:0]  err_code,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int unsigned CntW    = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LastIdx = 4'(NUM_ENTRIES - 1);

  state_e            state_q, state_d;
  logic [3:0]        index_q, index_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              done_q, done_d, err_q, err_d;
  logic [3:0]        err_index_q, err_index_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic              aw_fin, w_fin, timed_out;
  logic [31:0]       rom_addr, rom_data;

  hdmi_cfg_rom u_rom (
    .index (index_q),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    done_d      = done_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    aw_fin      = 1'b0;
    w_fin       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d      = 1'b0;
          err_d       = 1'b0;
          err_index_d = 4'd0;
          err_code_d  = ErrNone;
          index_d     = 4'd0;
          state_d     = StWrReq;
        end
      end
      StWrReq: begin
        aw_valid  = ~aw_done_q;
        w_valid   = ~w_done_q;
        aw_fin    = aw_done_q | M_AXI_AWREADY;
        w_fin     = w_done_q | M_AXI_WREADY;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          state_d = StWrResp;
        end else if (timed_out) begin
          state_d     = StErr;
          err_code_d  = ErrTimeout;
          err_index_d = index_q;
        end
      end
      StWrResp: begin
        b_ready = 1'b1;
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            state_d     = StErr;
            err_code_d  = ErrBresp;
            err_index_d = index_q;
          end else if (index_q == LastIdx) begin
            index_d = 4'd0;
            state_d = (VERIFY != 0) ? StRdReq : StDone;
          end else begin
            index_d = index_q + 4'd1;
            state_d = StWrReq;
          end
        end else if (timed_out) begin
          state_d     = StErr;
          err_code_d  = ErrTimeout;
          err_index_d = index_q;
        end
      end
      StRdReq: begin
        ar_valid = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = StRdResp;
        end else if (timed_out) begin
          state_d     = StErr;
          err_code_d  = ErrTimeout;
          err_index_d = index_q;
        end
      end
      StRdResp: begin
        r_ready = 1'b1;
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != rom_data) begin
            state_d     = StErr;
            err_code_d  = ErrRead;
            err_index_d = index_q;
          end else if (index_q == LastIdx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 4'd1;
            state_d = StRdReq;
          end
        end else if (timed_out) begin
          state_d     = StErr;
          err_code_d  = ErrTimeout;
          err_index_d = index_q;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Channel completion flags only live for the duration of one write request.
    if (state_d != StWrReq) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end

    if (state_d != state_q || state_q == StIdle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      index_q     <= 4'd0;
      cnt_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= 4'd0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign err           = err_q;
  assign err_index     = err_index_q;
  assign err_code      = err_code_q;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_AWADDR  = aw_valid ? rom_addr : 32'd0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_WDATA   = w_valid ? rom_data : 32'd0;
  assign M_AXI_WSTRB   = w_valid ? 4'hF : 4'h0;
  assign M_AXI_BREADY  = b_ready;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_ARADDR  = ar_valid ? rom_addr : 32'd0;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = r_ready;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Scoreboard bench: a behavioural memory slave plus a table-level model of the expected traffic.
module tb_hdmi_cfg_sequencer;

  localparam int N = 4;

  logic        ACLK, ARESETN, start;
  logic        busy, done, err;
  logic [3:0]  err_index;
  logic [1:0]  err_code;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  hdmi_cfg_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done), .err(err),
    .err_index(err_index), .err_code(err_code),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  // Scoreboard queues and the reference table.
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  logic [7:0]  exp_st[$];   // {done, err, code[1:0], index[3:0]}
  logic [31:0] ref_addr [N] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] ref_data [N] = '{32'h1, 32'h2, 32'h3, 32'h4};

  task automatic model_push(input int bad_b, input int bad_r, input bit stall);
    for (int i = 0; i < N; i++) begin
      exp_aw.push_back(ref_addr[i]);
      exp_w.push_back(ref_data[i]);
      if (i == bad_b) begin
        exp_st.push_back({2'b01, 2'b01, 4'(i)});
        return;
      end
    end
    if (stall) begin
      exp_st.push_back({2'b01, 2'b11, 4'd0});
      return;
    end
    for (int i = 0; i < N; i++) begin
      exp_ar.push_back(ref_addr[i]);
      if (i == bad_r) begin
        exp_st.push_back({2'b01, 2'b10, 4'(i)});
        return;
      end
    end
    exp_st.push_back({2'b10, 2'b00, 4'd0});
  endtask

  // Memory slave: decides readies/responses on the falling edge.
  int          cfg_bad_b = -1, cfg_bad_r = -1;
  bit          cfg_stall = 0, cfg_lead = 0, cfg_rand = 0;
  int          wr_cnt, rd_cnt, b_dly, r_dly, w_wait;
  bit          aw_got, w_got, b_pend, r_pend;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [31:0] cap_aw, cap_w, cap_ar, s_awaddr, s_wdata, s_araddr;
  logic [31:0] mem [16];

  function automatic logic rnd_ready();
    return cfg_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        wr_cnt = 0; rd_cnt = 0; b_dly = 0; r_dly = 0; w_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      end else begin
        if (hs_aw) begin aw_got = 1; s_awaddr = cap_aw; end
        if (hs_w) begin w_got = 1; s_wdata = cap_w; w_wait = 0; end
        if (hs_b) begin b_pend = 0; wr_cnt++; end
        if (hs_r) begin r_pend = 0; rd_cnt++; end
        if (hs_ar) begin
          r_pend = 1; s_araddr = cap_ar;
          r_dly = cfg_rand ? int'($urandom_range(0, 3)) : 0;
        end
        if (aw_got && w_got && !b_pend) begin
          b_pend = 1; aw_got = 0; w_got = 0;
          mem[s_awaddr[5:2]] = s_wdata;
          b_dly = cfg_rand ? int'($urandom_range(0, 3)) : 0;
        end
        M_AXI_AWREADY = !aw_got && rnd_ready();
        M_AXI_WREADY  = !w_got && rnd_ready();
        if (cfg_lead && wr_cnt == 2 && !b_pend) begin
          M_AXI_AWREADY = !aw_got;
          M_AXI_WREADY  = 1'b0;
          if (M_AXI_WVALID) begin
            M_AXI_WREADY = (w_wait >= 3);
            w_wait++;
          end
        end
        M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        if (b_pend) begin
          if (b_dly > 0) b_dly--;
          else begin
            M_AXI_BVALID = 1;
            M_AXI_BRESP  = (wr_cnt == cfg_bad_b) ? 2'b10 : 2'b00;
          end
        end
        M_AXI_ARREADY = !r_pend && !cfg_stall && rnd_ready();
        M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        if (r_pend) begin
          if (r_dly > 0) r_dly--;
          else begin
            M_AXI_RVALID = 1;
            M_AXI_RDATA  = (rd_cnt == cfg_bad_r) ? 32'h7 : mem[s_araddr[5:2]];
          end
        end
        hs_aw = M_AXI_AWVALID && M_AXI_AWREADY; cap_aw = M_AXI_AWADDR;
        hs_w  = M_AXI_WVALID && M_AXI_WREADY;   cap_w  = M_AXI_WDATA;
        hs_b  = M_AXI_BVALID && M_AXI_BREADY;
        hs_ar = M_AXI_ARVALID && M_AXI_ARREADY; cap_ar = M_AXI_ARADDR;
        hs_r  = M_AXI_RVALID && M_AXI_RREADY;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or a final status.
  bit fin_prev = 0;
  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (!ARESETN) fin_prev = 0;
      else begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          if (exp_aw.size() == 0) note_fail("aw_unexpected");
          else check("aw_addr", {M_AXI_AWPROT, M_AXI_AWADDR}, {3'b0, exp_aw.pop_front()});
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          if (exp_w.size() == 0) note_fail("w_unexpected");
          else check("w_data", {M_AXI_WSTRB, M_AXI_WDATA}, {4'hF, exp_w.pop_front()});
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          if (exp_ar.size() == 0) note_fail("ar_unexpected");
          else check("ar_addr", {M_AXI_ARPROT, M_AXI_ARADDR}, {3'b0, exp_ar.pop_front()});
        end
        if ((done || err) && !fin_prev) begin
          if (exp_st.size() == 0) note_fail("status_unexpected");
          else check("status", {done, err, err_code, err_index, busy}, {exp_st.pop_front(), 1'b0});
        end
        fin_prev = done || err;
      end
    end
  end

  function automatic logic [15:0] outs_vec();
    return {busy, done, err, err_index, err_code, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARVALID, M_AXI_RREADY, M_AXI_WSTRB == 4'h0 ? 1'b0 : 1'b1};
  endfunction

  task automatic flush();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_st.delete();
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    #1 ARESETN = 0;
    #1 check("reset_outputs", outs_vec(), 16'h0);
    flush();
    @(negedge ACLK);
    #1 ARESETN = 1;
  endtask

  task automatic start_run();
    @(negedge ACLK);
    start = 1;
    @(negedge ACLK);
    start = 0;
    #1 check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_end(input bit restart, output int cycles, output int arv);
    cycles = 0;
    arv = 0;
    while (!(done || err) && cycles < 3000) begin
      @(negedge ACLK);
      start = restart && (cycles == 4);
      #1;
      cycles++;
      if (M_AXI_ARVALID) arv++;
    end
    start = 0;
    if (cycles >= 3000) note_fail("end_timeout");
    repeat (3) @(negedge ACLK);
    #3;
    check("sticky_status", done || err, 1'b1);
    check("queues_empty", {exp_aw.size(), exp_w.size()} | {exp_ar.size(), exp_st.size()}, 64'h0);
  endtask

  task automatic set_cfg(input int bb, input int br, input bit st, input bit ld, input bit rn);
    cfg_bad_b = bb; cfg_bad_r = br; cfg_stall = st; cfg_lead = ld; cfg_rand = rn;
  endtask

  int cyc, arv;

  initial begin
    ARESETN = 0;
    start   = 0;
    #2 check("initial_reset", outs_vec(), 16'h0);

    // Zero-wait slave: full write + verify pass and exact latency.
    set_cfg(-1, -1, 0, 0, 0);
    do_reset();
    model_push(-1, -1, 0);
    start_run();
    wait_end(0, cyc, arv);
    check("done_latency", cyc, 17);

    // AW accepted three cycles ahead of W on entry 2.
    set_cfg(-1, -1, 0, 1, 0);
    do_reset();
    model_push(-1, -1, 0);
    start_run();
    wait_end(0, cyc, arv);

    // Bad write response on entry 1.
    set_cfg(1, -1, 0, 0, 0);
    do_reset();
    model_push(1, -1, 0);
    start_run();
    wait_end(0, cyc, arv);

    // Readback mismatch on entry 2.
    set_cfg(-1, 2, 0, 0, 0);
    do_reset();
    model_push(-1, 2, 0);
    start_run();
    wait_end(0, cyc, arv);

    // ARREADY never rises: timeout in the read request.
    set_cfg(-1, -1, 1, 0, 0);
    do_reset();
    model_push(-1, -1, 1);
    start_run();
    wait_end(0, cyc, arv);
    check("ar_timeout_cycles", arv, 255);

    // Reset while waiting for the entry-1 write response, then a clean rerun.
    set_cfg(-1, -1, 0, 0, 0);
    do_reset();
    model_push(-1, -1, 0);
    start_run();
    cyc = 0;
    while (!(M_AXI_BREADY && wr_cnt == 1) && cyc < 100) begin
      @(negedge ACLK);
      #1;
      cyc++;
    end
    if (cyc >= 100) note_fail("reach_wr_resp1");
    ARESETN = 0;
    #1 check("reset_mid_outputs", outs_vec(), 16'h0);
    flush();
    @(negedge ACLK);
    #1 ARESETN = 1;
    repeat (5) begin
      @(negedge ACLK);
      #1 check("no_completion_after_reset", {done, err, busy}, 3'b000);
    end
    model_push(-1, -1, 0);
    start_run();
    wait_end(0, cyc, arv);

    // Randomized waits and faults; some runs pulse start again mid-sequence.
    for (int r = 0; r < 8; r++) begin
      int sel, bb, br;
      sel = int'($urandom_range(0, 2));
      bb  = (sel == 1) ? int'($urandom_range(0, N - 1)) : -1;
      br  = (sel == 2) ? int'($urandom_range(0, N - 1)) : -1;
      set_cfg(bb, br, 0, 0, 1);
      do_reset();
      model_push(bb, br, 0);
      start_run();
      wait_end(r[0], cyc, arv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
